// File: rtl/scs8hd_bist_pkg.sv
// Shared types and constants for the o2bb2ai cell BIST controller.
package scs8hd_bist_pkg;

    localparam int unsigned VEC_W = 4;
    localparam int unsigned ERR_W = 5;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned PCNT_W = 3;

    // Expected Y for vector {A1N,A2N,B1,B2}: (A1N&A2N)|~(B1|B2)
    localparam logic [15:0] O2BB2AI_TT = 16'hF111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_FIN
    } bist_state_e;

endpackage

// File: rtl/scs8hd_bist_settle_cnt.sv
// Settle-time counter: loadable 4-bit down counter with a zero flag.
module scs8hd_bist_settle_cnt
    import scs8hd_bist_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/scs8hd_o2bb2ai_bist.sv
// BIST sequencer: sweeps all 16 input vectors of an o2bb2ai cell and
// counts mismatches between the observed and expected output.
module scs8hd_o2bb2ai_bist
    import scs8hd_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned PASSES     = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ABORT,
    input  logic             Y_OBS,
    output logic             A1N,
    output logic             A2N,
    output logic             B1,
    output logic             B2,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [VEC_W-1:0] FAIL_VEC
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    bist_state_e       state_q, state_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [VEC_W-1:0]  stim_q, stim_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [VEC_W-1:0]  fvec_q, fvec_d;
    logic              pass_q, pass_d;
    logic              busy_q, done_q;
    logic              cnt_load, cnt_dec, cnt_zero_c;

    scs8hd_bist_settle_cnt u_settle_cnt (
        .clk      (CLK),
        .reset    (RESET),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero_c)
    );

    // Next-state and next-output decode
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        pcnt_d   = pcnt_q;
        stim_d   = stim_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        pass_d   = pass_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        case (state_q)
            S_IDLE: begin
                stim_d = '0;
                if (START && !ABORT) begin
                    state_d = S_APPLY;
                    vec_d   = '0;
                    pcnt_d  = '0;
                    err_d   = '0;
                    fvec_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                stim_d = vec_q;
                if (SETTLE_CYC == 0) begin
                    state_d = S_SAMPLE;
                end else begin
                    state_d  = S_SETTLE;
                    cnt_load = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_zero_c) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_SAMPLE: begin
                if (Y_OBS != O2BB2AI_TT[vec_q]) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    // err_q is still zero only on the first mismatch of the run
                    if (err_q == '0) begin
                        fvec_d = vec_q;
                    end
                end
                if (vec_q != '1) begin
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = S_APPLY;
                end else if ((32'(pcnt_q) + 32'd1) < PASSES) begin
                    vec_d   = '0;
                    pcnt_d  = pcnt_q + PCNT_W'(1);
                    state_d = S_APPLY;
                end else begin
                    state_d = S_FIN;
                    stim_d  = '0;
                    pass_d  = (err_d == '0);
                end
            end
            S_FIN: begin
                stim_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                stim_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        // Abort drops the run in flight; results gathered so far are kept
        if (ABORT && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            stim_d   = '0;
            err_d    = err_q;
            fvec_d   = fvec_q;
            pass_d   = pass_q;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            pcnt_q  <= '0;
            stim_q  <= '0;
            err_q   <= '0;
            fvec_q  <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pcnt_q  <= pcnt_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            pass_q  <= pass_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_FIN);
        end
    end

    assign A1N      = stim_q[3];
    assign A2N      = stim_q[2];
    assign B1       = stim_q[1];
    assign B2       = stim_q[0];
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERR_CNT  = err_q;
    assign FAIL_VEC = fvec_q;

endmodule

// File: tb/tb_scs8hd_o2bb2ai_bist.sv
// Bench for the o2bb2ai BIST controller: a default instance and a 4-pass instance.
module tb_scs8hd_o2bb2ai_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start0 = 1'b0, abort0 = 1'b0, y0 = 1'b0;
    logic start4 = 1'b0, abort4 = 1'b0, y4 = 1'b0;
    logic a1n0, a2n0, b10, b20, busy0, done0, pass0;
    logic a1n4, a2n4, b14, b24, busy4, done4, pass4;
    logic [4:0] err0, err4;
    logic [3:0] fv0, fv4;

    int n_checks = 0;
    int n_fail = 0;

    // Cell fault model: 0 = correct with inversion mask, 1 = stuck 0, 2 = stuck 1
    int          fmode = 0;
    logic [15:0] inv_mask = 16'h0;

    scs8hd_o2bb2ai_bist dut0 (
        .CLK(clk), .RESET(reset), .START(start0), .ABORT(abort0), .Y_OBS(y0),
        .A1N(a1n0), .A2N(a2n0), .B1(b10), .B2(b20), .BUSY(busy0), .DONE(done0),
        .PASS(pass0), .ERR_CNT(err0), .FAIL_VEC(fv0)
    );

    scs8hd_o2bb2ai_bist #(.SETTLE_CYC(2), .PASSES(4)) dut4 (
        .CLK(clk), .RESET(reset), .START(start4), .ABORT(abort4), .Y_OBS(y4),
        .A1N(a1n4), .A2N(a2n4), .B1(b14), .B2(b24), .BUSY(busy4), .DONE(done4),
        .PASS(pass4), .ERR_CNT(err4), .FAIL_VEC(fv4)
    );

    function automatic logic cell_y(input logic [3:0] v);
        logic good;
        good = (v[3] & v[2]) | ~(v[1] | v[0]);
        if (fmode == 1) return 1'b0;
        if (fmode == 2) return 1'b1;
        return good ^ inv_mask[v];
    endfunction

    // Observed cell output lags the stimulus by one cycle
    always @(posedge clk) begin
        y0 <= cell_y({a1n0, a2n0, b10, b20});
        y4 <= cell_y({a1n4, a2n4, b14, b24});
    end

    function automatic int popcount16(input logic [15:0] m);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic logic [3:0] first_set(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return 4'(i);
        return 4'h0;
    endfunction

    // Pulse START, then count cycles from APPLY entry until DONE is seen.
    task automatic run_wait(input bit use4, input int budget, input int restart_at,
                            output int cycles);
        int k = 0;
        @(negedge clk);
        if (use4) start4 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start4 = 1'b0;
        while (k < budget && !(use4 ? done4 : done0)) begin
            @(negedge clk);
            k++;
            if (use4) start4 = (k == restart_at); else start0 = (k == restart_at);
        end
        start0 = 1'b0; start4 = 1'b0;
        cycles = k;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({a1n0, a2n0, b10, b20, busy0, done0, pass0, err0, fv0} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_dut0: got %h expected 0000",
                     {a1n0, a2n0, b10, b20, busy0, done0, pass0, err0, fv0});
        end
        n_checks++;
        if ({a1n4, a2n4, b14, b24, busy4, done4, pass4, err4, fv4} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_dut4: got %h expected 0000",
                     {a1n4, a2n4, b14, b24, busy4, done4, pass4, err4, fv4});
        end
    endtask

    task automatic test_good_run();
        int cyc;
        fmode = 0; inv_mask = 16'h0;
        run_wait(1'b0, 200, 20, cyc);
        n_checks++;
        if (cyc !== 64) begin
            n_fail++; $display("FAIL good_latency: got %0d expected 64", cyc);
        end
        n_checks++;
        if ({pass0, err0, fv0, a1n0, a2n0, b10, b20, busy0} !== {1'b1, 5'd0, 4'h0, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL good_status: pass=%b err=%0d fv=%h stim=%b busy=%b expected pass=1 err=0 fv=0 stim=0000 busy=1",
                     pass0, err0, fv0, {a1n0, a2n0, b10, b20}, busy0);
        end
        @(negedge clk);
        n_checks++;
        if ({done0, busy0, pass0} !== 3'b001) begin
            n_fail++; $display("FAIL good_after_done: done/busy/pass=%b expected 001", {done0, busy0, pass0});
        end
    endtask

    task automatic test_stuck0();
        int cyc;
        fmode = 1;
        run_wait(1'b0, 200, -1, cyc);
        n_checks++;
        if ({cyc, pass0, err0, fv0} !== {32'd64, 1'b0, 5'd7, 4'h0}) begin
            n_fail++;
            $display("FAIL stuck0: cyc=%0d pass=%b err=%0d fv=%h expected 64 0 7 0", cyc, pass0, err0, fv0);
        end
    endtask

    task automatic test_inv5();
        int cyc;
        fmode = 0; inv_mask = 16'h0020;
        run_wait(1'b0, 200, -1, cyc);
        n_checks++;
        if ({cyc, pass0, err0, fv0} !== {32'd64, 1'b0, 5'd1, 4'h5}) begin
            n_fail++;
            $display("FAIL inv5: cyc=%0d pass=%b err=%0d fv=%h expected 64 0 1 5", cyc, pass0, err0, fv0);
        end
    endtask

    task automatic test_passes4_stuck1();
        int cyc;
        fmode = 2;
        run_wait(1'b1, 400, -1, cyc);
        n_checks++;
        if (cyc !== 256) begin
            n_fail++; $display("FAIL p4_latency: got %0d expected 256", cyc);
        end
        n_checks++;
        if ({pass4, err4, fv4} !== {1'b0, 5'd31, 4'h1}) begin
            n_fail++;
            $display("FAIL p4_stuck1: pass=%b err=%0d fv=%h expected 0 31 1", pass4, err4, fv4);
        end
    endtask

    task automatic test_abort();
        bit saw_done = 1'b0;
        fmode = 1;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (9) @(negedge clk);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        n_checks++;
        if ({busy0, done0, a1n0, a2n0, b10, b20} !== 6'b0) begin
            n_fail++; $display("FAIL abort_idle: busy/done/stim=%b expected 000000",
                               {busy0, done0, a1n0, a2n0, b10, b20});
        end
        n_checks++;
        if ({pass0, err0, fv0} !== {1'b0, 5'd1, 4'h0}) begin
            n_fail++; $display("FAIL abort_hold: pass=%b err=%0d fv=%h expected 0 1 0", pass0, err0, fv0);
        end
        repeat (80) begin
            @(negedge clk);
            if (done0 || busy0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_done: activity=%b expected 0", saw_done);
        end
        abort0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0; start0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy0, err0} !== {1'b0, 5'd1}) begin
            n_fail++; $display("FAIL abort_start_idle: busy=%b err=%0d expected 0 1", busy0, err0);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        fmode = 1;
        @(negedge clk); start0 = 1'b1; start4 = 1'b1;
        @(negedge clk); start0 = 1'b0; start4 = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({a1n0, a2n0, b10, b20, busy0, done0, pass0, err0, fv0} !== 16'h0) begin
            n_fail++; $display("FAIL midrun_reset: got %h expected 0000",
                               {a1n0, a2n0, b10, b20, busy0, done0, pass0, err0, fv0});
        end
        n_checks++;
        if ({busy4, done4, err4} !== 7'h0) begin
            n_fail++; $display("FAIL midrun_reset_p4: got %h expected 00", {busy4, done4, err4});
        end
        fmode = 0; inv_mask = 16'h0;
        run_wait(1'b0, 200, -1, cyc);
        n_checks++;
        if ({cyc, pass0, err0} !== {32'd64, 1'b1, 5'd0}) begin
            n_fail++; $display("FAIL post_reset_run: cyc=%0d pass=%b err=%0d expected 64 1 0", cyc, pass0, err0);
        end
    endtask

    task automatic test_random();
        int cyc, pop, exp_err;
        for (int it = 0; it < 6; it++) begin
            bit use4 = (it % 3 == 2);
            fmode = 0;
            inv_mask = (it == 0) ? 16'h0 : 16'($urandom_range(0, 65535));
            pop = popcount16(inv_mask) * (use4 ? 4 : 1);
            exp_err = (pop > 31) ? 31 : pop;
            run_wait(use4, 400, -1, cyc);
            n_checks++;
            if (use4) begin
                if ({cyc, pass4, err4, fv4} !== {32'd256, (pop == 0), 5'(exp_err), first_set(inv_mask)}) begin
                    n_fail++;
                    $display("FAIL random_p4 mask=%h: cyc=%0d pass=%b err=%0d fv=%h expected 256 %b %0d %h",
                             inv_mask, cyc, pass4, err4, fv4, (pop == 0), exp_err, first_set(inv_mask));
                end
            end else begin
                if ({cyc, pass0, err0, fv0} !== {32'd64, (pop == 0), 5'(exp_err), first_set(inv_mask)}) begin
                    n_fail++;
                    $display("FAIL random_p1 mask=%h: cyc=%0d pass=%b err=%0d fv=%h expected 64 %b %0d %h",
                             inv_mask, cyc, pass0, err0, fv0, (pop == 0), exp_err, first_set(inv_mask));
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_good_run();
        test_stuck0();
        test_inv5();
        test_passes4_stuck1();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
